// File: rtl/instr_readback_engine.sv
// Readback engine for the 32-entry instruction register.
// Walks the read port over a wrapping range, streams words out and flags recompute mismatches.

package instr_register_pkg;
   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;
   typedef logic [4:0]         address_t;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  result;
   } instruction_t;
endpackage

// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | capturing entries whenever the output slot is free or draining
// DRAIN | last entry captured, waiting for it to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module instr_readback_engine
   import instr_register_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  address_t     base_addr,
   input  logic [5:0]   count,
   output address_t     read_pointer,
   input  instruction_t instruction_word,
   output logic         out_valid,
   input  logic         out_ready,
   output instruction_t out_instr,
   output address_t     out_addr,
   output logic         out_mismatch,
   output logic         out_divzero,
   output logic         busy,
   output logic         done,
   output logic [5:0]   err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state;
   logic [5:0] remaining;
   logic       cap;
   result_t    op_a64;
   result_t    op_b64;
   result_t    calc;
   logic       divzero_c;
   logic       mismatch_c;

   assign cap = (state == RUN) && (!out_valid || out_ready);

   always_comb begin
      op_a64    = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
      op_b64    = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
      calc      = '0;
      divzero_c = 1'b0;
      case (instruction_word.opc)
         ZERO:  calc = '0;
         PASSA: calc = op_a64;
         PASSB: calc = op_b64;
         ADD:   calc = op_a64 + op_b64;
         SUB:   calc = op_a64 - op_b64;
         MULT:  calc = op_a64 * op_b64;
         DIV: begin
            if (op_b64 == '0) divzero_c = 1'b1;
            else              calc = op_a64 / op_b64;
         end
         MOD: begin
            if (op_b64 == '0) divzero_c = 1'b1;
            else              calc = op_a64 % op_b64;
         end
         default: calc = '0;
      endcase
      mismatch_c = !divzero_c && (calc != instruction_word.result);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         read_pointer <= '0;
         remaining    <= '0;
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_addr     <= '0;
         out_mismatch <= 1'b0;
         out_divzero  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_count    <= '0;
      end else begin
         done <= 1'b0;

         if (cap) begin
            out_valid    <= 1'b1;
            out_instr    <= instruction_word;
            out_addr     <= read_pointer;
            out_mismatch <= mismatch_c;
            out_divzero  <= divzero_c;
            read_pointer <= read_pointer + 5'd1;
            remaining    <= remaining - 6'd1;
            if (mismatch_c && (err_count != 6'd63))
               err_count <= err_count + 6'd1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (count != 6'd0) begin
                     state        <= RUN;
                     read_pointer <= base_addr;
                     remaining    <= count;
                     err_count    <= '0;
                     busy         <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (cap && (remaining == 6'd1)) state <= DRAIN;
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_readback_engine.sv
// Scoreboard bench for instr_readback_engine: a register-file model feeds the read port,
// expected words are queued at start and popped on each accepted handshake.

module tb_instr_readback_engine;
   import instr_register_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   address_t     base_addr = '0;
   logic [5:0]   count = '0;
   address_t     read_pointer;
   instruction_t instruction_word;
   logic         out_valid;
   logic         out_ready = 1'b1;
   instruction_t out_instr;
   address_t     out_addr;
   logic         out_mismatch;
   logic         out_divzero;
   logic         busy;
   logic         done;
   logic [5:0]   err_count;

   typedef struct {
      address_t     a;
      instruction_t w;
      logic         mm;
      logic         dz;
   } exp_t;

   instruction_t mem [32];
   bit           mm_exp [32];
   bit           dz_exp [32];
   exp_t         sb [$];
   int           n_chk = 0;
   int           n_pass = 0;
   int           exp_err = 0;

   always #5 clk = ~clk;

   assign instruction_word = mem[read_pointer];

   instr_readback_engine dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .start            (start),
      .base_addr        (base_addr),
      .count            (count),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_addr         (out_addr),
      .out_mismatch     (out_mismatch),
      .out_divzero      (out_divzero),
      .busy             (busy),
      .done             (done),
      .err_count        (err_count)
   );

   task automatic check_val(input string tag, input logic [131:0] got, input logic [131:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic set_e(input int i, input opcode_t o, input int a, input int b,
                        input longint r, input bit mm, input bit dz);
      mem[i].opc    = o;
      mem[i].op_a   = a;
      mem[i].op_b   = b;
      mem[i].result = r;
      mm_exp[i]     = mm;
      dz_exp[i]     = dz;
   endtask

   // Accepted words are compared in order against the queue.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_val("sb_unexpected_word", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("out_addr", out_addr, e.a);
            check_val("out_instr", out_instr, e.w);
            check_val("out_mismatch", out_mismatch, e.mm);
            check_val("out_divzero", out_divzero, e.dz);
         end
      end
   end

   task automatic push_expected(input int b, input int c);
      exp_t e;
      exp_err = 0;
      for (int k = 0; k < c; k++) begin
         e.a  = address_t'((b + k) % 32);
         e.w  = mem[e.a];
         e.mm = mm_exp[e.a];
         e.dz = dz_exp[e.a];
         if (e.mm && exp_err < 63) exp_err++;
         sb.push_back(e);
      end
   endtask

   task automatic issue_start(input int b, input int c);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = address_t'(b);
      count     = 6'(c);
      @(posedge clk); #1;
      start = 1'b0;
      if (c != 0) begin
         check_val("busy_after_start", busy, 1);
         check_val("rp_after_start", read_pointer, address_t'(b));
      end else begin
         check_val("busy_zero_count", busy, 0);
      end
   endtask

   task automatic wait_done(input int c, input int exp_lat);
      int lat;
      bit seen;
      seen = 0;
      lat  = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            lat  = i;
            break;
         end
      end
      check_val("done_seen", seen, 1);
      if (seen) begin
         if (exp_lat > 0) check_val("done_latency", lat, exp_lat);
         check_val("sb_drained", sb.size(), 0);
         if (c != 0) check_val("err_count", err_count, exp_err);
         check_val("valid_at_done", out_valid, 0);
         @(negedge clk);
         check_val("done_one_cycle", done, 0);
         check_val("busy_after_done", busy, 0);
      end
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) set_e(i, PASSA, i, 100, i, 0, 0);
      set_e(0, ADD, 5, 3, 8, 0, 0);
      set_e(1, SUB, 2, 7, -5, 0, 0);
      set_e(2, MULT, -4, 6, -24, 0, 0);
      set_e(20, ADD, 5, 3, 9, 1, 0);
      set_e(21, DIV, 7, 0, 0, 0, 1);
      set_e(22, DIV, -7, 2, -3, 0, 0);
      set_e(23, MOD, -7, 2, -1, 0, 0);
      set_e(24, MULT, 32'h7fffffff, 32'h7fffffff, 64'h3fffffff00000001, 0, 0);
      set_e(25, ZERO, 9, 9, 0, 0, 0);

      #12;
      check_val("rst_valid", out_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_rp", read_pointer, 0);
      check_val("rst_err", err_count, 0);
      reset_n = 1'b1;

      // linear readback, full throughput
      push_expected(0, 3);
      issue_start(0, 3);
      wait_done(3, 5);

      // mismatch, divide-by-zero, signed div/mod, wide multiply
      push_expected(20, 6);
      issue_start(20, 6);
      wait_done(6, 8);

      // wrap 30,31,0,1
      push_expected(30, 4);
      issue_start(30, 4);
      wait_done(4, 6);

      // backpressure
      out_ready = 1'b0;
      push_expected(10, 4);
      issue_start(10, 4);
      begin
         bit got_valid;
         address_t snap_a, snap_rp;
         instruction_t snap_w;
         got_valid = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
               got_valid = 1;
               break;
            end
         end
         check_val("bp_first_valid", got_valid, 1);
         snap_a  = out_addr;
         snap_w  = out_instr;
         snap_rp = read_pointer;
         check_val("bp_rp_advanced", snap_rp, 5'd11);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_valid_hold", out_valid, 1);
            check_val("bp_addr_hold", out_addr, snap_a);
            check_val("bp_instr_hold", out_instr, snap_w);
            check_val("bp_rp_frozen", read_pointer, snap_rp);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(4, 0);

      // start during RUN must be ignored
      push_expected(0, 5);
      issue_start(0, 5);
      start     = 1'b1;
      base_addr = 5'd15;
      count     = 6'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("busy_ignore_start", busy, 1);
      wait_done(5, 0);

      // zero-length start
      issue_start(7, 0);
      wait_done(0, 1);

      // reset mid-run with a held word
      out_ready = 1'b0;
      push_expected(0, 8);
      issue_start(0, 8);
      repeat (3) @(negedge clk);
      check_val("pre_rst_valid", out_valid, 1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_valid", out_valid, 0);
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_rp", read_pointer, 0);
      check_val("mid_rst_addr", out_addr, 0);
      check_val("mid_rst_instr", out_instr, 0);
      check_val("mid_rst_err", err_count, 0);
      sb.delete();
      repeat (2) begin
         @(negedge clk);
         check_val("mid_rst_no_done", done, 0);
      end
      @(posedge clk); #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check_val("post_rst_no_done", done, 0);

      // full 32-entry sweep from base 5, ending on 4
      push_expected(5, 32);
      issue_start(5, 32);
      wait_done(32, 34);
      check_val("sweep_rp_end", read_pointer, 5'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
